// File: rtl/countdown_nounder_if.sv
// Bus bundle for countdown_nounder: load/enable controls in, count and
// status flags out. clk/rst stay plain ports on the module.
interface countdown_nounder_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             busy;
  logic             done_pulse;

  modport master (
    output load, load_val, enable,
    input  out, zero, busy, done_pulse
  );

  modport slave (
    input  load, load_val, enable,
    output out, zero, busy, done_pulse
  );
endinterface

// File: rtl/countdown_nounder.sv
// countdown_nounder: loadable saturating down-counter with a one-cycle
// done pulse when the count first reaches zero. IDLE/RUN/DONE FSM.
// Optional macro AUTO_RELOAD_EN: on reaching the terminal count the counter
// reloads its last load value and keeps running (periodic tick) instead of
// parking in DONE at zero.
module countdown_nounder #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  countdown_nounder_if.slave cnt_if
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next state: load beats enable; decrement only while RUN. Terminal count
  // is detected at out==1 so the pulse lands in the cycle out reads 0
  // (or reads the reload value in auto-reload mode).
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (cnt_if.load) begin
      out_d   = cnt_if.load_val;
`ifdef AUTO_RELOAD_EN
      reload_d = cnt_if.load_val;
`endif
      state_d = (cnt_if.load_val != '0) ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (cnt_if.enable) begin
            if (out_q == ONE) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              out_d  = reload_q;
`else
              out_d   = '0;
              state_d = S_DONE;
`endif
            end else begin
              out_d = out_q - ONE;
            end
          end
        end
        // DONE and IDLE both sit at zero; enable cannot underflow them.
        S_DONE:  out_d = '0;
        default: out_d = '0;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      done_q   <= done_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign cnt_if.out        = out_q;
  assign cnt_if.zero       = (out_q == '0);
  assign cnt_if.busy       = (state_q == S_RUN);
  assign cnt_if.done_pulse = done_q;

endmodule
